// File: rtl/fft_pkg.sv
// Shared constants, state encoding and address type for the 32-point FFT memory sequencer.
package fft_pkg;
  localparam int FFT_N     = 32;
  localparam int FFT_LOG2N = 5;
  localparam int ADDR_W    = 5;
  localparam int TW_W      = 4;
  localparam int BFLY_N    = FFT_N / 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/fft_mem_sequencer_if.sv
// Control/address bundle between the FFT sequencer (master) and the memory/butterfly datapath (slave).
interface fft_mem_sequencer_if;
  import fft_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic              select;
  logic              write_enable;
  logic              rd_valid;
  addr_t             addr_1;
  addr_t             addr_2;
  addr_t             addw_1;
  addr_t             addw_2;
  logic [TW_W-1:0]   tw_addr;

  modport master (
    input  start,
    output busy, done, select, write_enable, rd_valid,
    output addr_1, addr_2, addw_1, addw_2, tw_addr
  );

  modport slave (
    output start,
    input  busy, done, select, write_enable, rd_valid,
    input  addr_1, addr_2, addw_1, addw_2, tw_addr
  );
endinterface

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with asynchronous clear; output is the input delayed by DEPTH cycles.
module fft_delay_line #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/fft_mem_sequencer.sv
// Sequences read/twiddle/write addresses for a 5-stage radix-2 DIT FFT over a ping-pong memory,
// one butterfly per cycle, draining the butterfly pipeline before flipping the bank select.
module fft_mem_sequencer
  import fft_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input logic                 clk,
  input logic                 rst,
  fft_mem_sequencer_if.master bus
);
  localparam logic [3:0] DRAIN_LAST = 4'(LATENCY - 1);
  localparam logic [3:0] BFLY_LAST  = 4'(BFLY_N - 1);
  localparam logic [2:0] STAGE_LAST = 3'(FFT_LOG2N - 1);

  state_t     state, state_nxt;
  logic [2:0] stage, stage_nxt;
  logic [3:0] bfly, bfly_nxt;
  logic [3:0] dcnt, dcnt_nxt;
  logic       sel, sel_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      stage <= '0;
      bfly  <= '0;
      dcnt  <= '0;
      sel   <= 1'b0;
    end else begin
      state <= state_nxt;
      stage <= stage_nxt;
      bfly  <= bfly_nxt;
      dcnt  <= dcnt_nxt;
      sel   <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    bfly_nxt  = bfly;
    dcnt_nxt  = dcnt;
    sel_nxt   = sel;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          stage_nxt = '0;
          bfly_nxt  = '0;
          sel_nxt   = 1'b0;
        end
      end
      RUN: begin
        bfly_nxt = bfly + 4'd1;
        if (bfly == BFLY_LAST) begin
          state_nxt = DRAIN;
          dcnt_nxt  = '0;
        end
      end
      DRAIN: begin
        dcnt_nxt = dcnt + 4'd1;
        // The last write of this stage lands on this cycle with the old select.
        if (dcnt == DRAIN_LAST) begin
          sel_nxt = ~sel;
          if (stage < STAGE_LAST) begin
            stage_nxt = stage + 3'd1;
            bfly_nxt  = '0;
            state_nxt = RUN;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic [4:0] span, pos, grp, a1, tw_full;
  logic       rd_valid;

  always_comb begin
    span    = 5'd1 << stage;
    pos     = {1'b0, bfly} & (span - 5'd1);
    grp     = {1'b0, bfly} >> stage;
    a1      = (grp << (stage + 3'd1)) + pos;
    tw_full = pos << (3'd4 - stage);
  end

  assign rd_valid     = (state == RUN);
  assign bus.rd_valid = rd_valid;
  assign bus.addr_1   = rd_valid ? a1 : '0;
  assign bus.addr_2   = rd_valid ? (a1 + span) : '0;
  assign bus.tw_addr  = rd_valid ? tw_full[3:0] : '0;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.select   = sel;

  logic [2*ADDR_W:0] wr_dout;

  fft_delay_line #(
    .WIDTH (2*ADDR_W + 1),
    .DEPTH (LATENCY)
  ) u_wr_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({rd_valid, bus.addr_1, bus.addr_2}),
    .dout (wr_dout)
  );

  assign bus.write_enable = wr_dout[2*ADDR_W];
  assign bus.addw_1       = wr_dout[2*ADDR_W-1:ADDR_W];
  assign bus.addw_2       = wr_dout[ADDR_W-1:0];
endmodule
